// File: rtl/pattern_count_ctrl.sv
// Memory front-end for the pattern counter: fetches pattern + 8-byte string,
// samples the three counts and writes them back to memory.
module pattern_count_ctrl #(
  parameter logic [7:0] PAT_ADDR = 8'd6,
  parameter logic [7:0] STR_BASE = 8'd32,
  parameter logic [7:0] RES_BASE = 8'd40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wdata,
  output logic [3:0]  cnt_pat,
  output logic [63:0] cnt_str,
  input  logic [7:0]  cnt_ctb,
  input  logic [7:0]  cnt_cts,
  input  logic [7:0]  cnt_cto,
  output logic [7:0]  res_ctb,
  output logic [7:0]  res_cts,
  output logic [7:0]  res_cto,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE, READ, DRAIN, SAMPLE, WR0, WR1, WR2, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        cap_en_q;
  logic [3:0]  cap_idx_q;
  logic [3:0]  cnt_pat_q;
  logic [63:0] cnt_str_q;
  logic [7:0]  res_ctb_q, res_cts_q, res_cto_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = 8'd0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = 8'd0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          idx_d   = 4'd0;
        end
      end
      READ: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        // idx 0 fetches the pattern, idx 1..8 walk the string (8-bit wrap)
        mem_addr  = (idx_q == 4'd0) ? PAT_ADDR : STR_BASE + {4'd0, idx_q} - 8'd1;
        if (idx_q == 4'd8) state_d = DRAIN;
        else               idx_d   = idx_q + 4'd1;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        busy    = 1'b1;
        state_d = WR0;
      end
      WR0: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = RES_BASE;
        mem_wdata = res_ctb_q;
        state_d   = WR1;
      end
      WR1: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = RES_BASE + 8'd1;
        mem_wdata = res_cts_q;
        state_d   = WR2;
      end
      WR2: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = RES_BASE + 8'd2;
        mem_wdata = res_cto_q;
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data arrives one cycle after the strobe, so steer it with a delayed index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_en_q  <= 1'b0;
      cap_idx_q <= 4'd0;
      cnt_pat_q <= 4'd0;
      cnt_str_q <= 64'd0;
    end else begin
      cap_en_q  <= mem_rd_en;
      cap_idx_q <= idx_q;
      if (cap_en_q) begin
        if (cap_idx_q == 4'd0) cnt_pat_q <= mem_rdata[3:0];
        for (int b = 0; b < 8; b++) begin
          if (cap_idx_q == 4'(b + 1)) cnt_str_q[63 - 8*b -: 8] <= mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_ctb_q <= 8'd0;
      res_cts_q <= 8'd0;
      res_cto_q <= 8'd0;
    end else if (state_q == SAMPLE) begin
      res_ctb_q <= cnt_ctb;
      res_cts_q <= cnt_cts;
      res_cto_q <= cnt_cto;
    end
  end

  assign cnt_pat   = cnt_pat_q;
  assign cnt_str   = cnt_str_q;
  assign res_ctb   = res_ctb_q;
  assign res_cts   = res_cts_q;
  assign res_cto   = res_cto_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pattern_count_ctrl.sv
// Bench for pattern_count_ctrl: byte memory model, stub counter, and a
// scoreboard of expected memory accesses checked on every strobe.
module tb_pattern_count_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, mem_rd_en, mem_wr_en;
  logic [7:0]  mem_addr, mem_wdata;
  logic [7:0]  mem_rdata;
  logic [3:0]  cnt_pat;
  logic [63:0] cnt_str;
  logic [7:0]  stub_ctb = 8'd0, stub_cts = 8'd0, stub_cto = 8'd0;
  logic [7:0]  res_ctb, res_cts, res_cto;
  logic [2:0]  dbg_state;

  // second instance with a wrapping string base
  logic        w_start = 1'b0;
  logic        w_busy, w_done, w_rd_en, w_wr_en;
  logic [7:0]  w_addr, w_wdata, w_rdata;
  logic [3:0]  w_cnt_pat;
  logic [63:0] w_cnt_str;
  logic [7:0]  w_zero = 8'd0;
  logic [7:0]  w_res_ctb, w_res_cts, w_res_cto;
  logic [2:0]  w_dbg_state;

  logic [7:0]  mem  [256];
  logic [7:0]  wmem [256];

  logic [16:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  wire [111:0] all_out = {busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
                          cnt_pat, cnt_str, res_ctb, res_cts, res_cto};

  pattern_count_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .cnt_pat(cnt_pat), .cnt_str(cnt_str),
    .cnt_ctb(stub_ctb), .cnt_cts(stub_cts), .cnt_cto(stub_cto),
    .res_ctb(res_ctb), .res_cts(res_cts), .res_cto(res_cto),
    .dbg_state(dbg_state)
  );

  pattern_count_ctrl #(.STR_BASE(8'hFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(w_start), .busy(w_busy), .done(w_done),
    .mem_addr(w_addr), .mem_rd_en(w_rd_en), .mem_rdata(w_rdata),
    .mem_wr_en(w_wr_en), .mem_wdata(w_wdata),
    .cnt_pat(w_cnt_pat), .cnt_str(w_cnt_str),
    .cnt_ctb(w_zero), .cnt_cts(w_zero), .cnt_cto(w_zero),
    .res_ctb(w_res_ctb), .res_cts(w_res_cts), .res_cto(w_res_cto),
    .dbg_state(w_dbg_state)
  );

  // clock / memory models
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (w_rd_en)   w_rdata <= wmem[w_addr];
    if (w_wr_en)   wmem[w_addr] <= w_wdata;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // scoreboard: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (mem_rd_en && mem_wr_en) begin
      n_tests++;
      n_fail++;
      $display("FAIL strobe_excl: got rd=1 wr=1 want one-hot");
    end
    if (mem_rd_en || mem_wr_en) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_access: got wr=%0b addr=%h want none", mem_wr_en, mem_addr);
      end else begin
        logic [16:0] e, a;
        e = exp_q.pop_front();
        a = {mem_wr_en, mem_addr, mem_wr_en ? mem_wdata : 8'h00};
        if (a !== e) begin
          n_fail++;
          $display("FAIL mem_access: got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                   a[16], a[15:8], a[7:0], e[16], e[15:8], e[7:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic push_run(input logic [7:0] ctb, input logic [7:0] cts, input logic [7:0] cto);
    exp_q.push_back({1'b0, 8'h06, 8'h00});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 8'(8'h20 + i), 8'h00});
    exp_q.push_back({1'b1, 8'h28, ctb});
    exp_q.push_back({1'b1, 8'h29, cts});
    exp_q.push_back({1'b1, 8'h2A, cto});
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (all_out !== 112'd0 || dbg_state !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_hold: got %h want 0", all_out);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_tests++;
      if (all_out !== 112'd0) begin
        n_fail++;
        $display("FAIL reset_idle: cycle %0d got %h want 0", c, all_out);
      end
    end
  endtask

  task automatic test_basic;
    mem[6] = 8'hA3;
    for (int i = 0; i < 8; i++) mem[32 + i] = 8'(8'h01 + 8'h22 * i);
    stub_ctb = 8'h0A; stub_cts = 8'h11; stub_cto = 8'h03;
    push_run(8'h0A, 8'h11, 8'h03);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      n_tests++;
      if (busy !== (c <= 14) || done !== (c == 15)) begin
        n_fail++;
        $display("FAIL basic_busy_done: cycle %0d got busy=%0b done=%0b", c, busy, done);
      end
      if (c == 11) begin
        n_tests++;
        if (cnt_pat !== 4'h3 || cnt_str !== 64'h0123456789ABCDEF) begin
          n_fail++;
          $display("FAIL basic_cnt: got pat=%h str=%h want 3 0123456789abcdef", cnt_pat, cnt_str);
        end
      end
    end
    n_tests++;
    if ({mem[40], mem[41], mem[42]} !== 24'h0A1103 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_results: got %h%h%h left=%0d want 0a1103 left=0",
               mem[40], mem[41], mem[42], exp_q.size());
    end
  endtask

  task automatic test_addr_seq;
    logic [3:0]  e_pat;
    logic [63:0] e_str;
    logic [7:0]  b;
    b = 8'($urandom_range(0, 255));
    mem[6] = b;
    e_pat = b[3:0];
    e_str = '0;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      mem[32 + i] = b;
      e_str = {e_str[55:0], b};
    end
    stub_ctb = 8'($urandom_range(0, 8));
    stub_cts = 8'($urandom_range(0, 8));
    stub_cto = 8'($urandom_range(0, 8));
    push_run(stub_ctb, stub_cts, stub_cto);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 11) begin
        n_tests++;
        if (cnt_pat !== e_pat || cnt_str !== e_str) begin
          n_fail++;
          $display("FAIL rand_cnt: got pat=%h str=%h want %h %h", cnt_pat, cnt_str, e_pat, e_str);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL addr_seq_left: got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_wrap;
    logic [7:0]  seen[$];
    logic [7:0]  want_a;
    logic [63:0] e_str;
    wmem[6] = 8'h5C;
    e_str = '0;
    for (int i = 0; i < 8; i++) begin
      want_a = 8'(8'hFC + i);
      wmem[want_a] = 8'(8'h90 + i);
      e_str = {e_str[55:0], 8'(8'h90 + i)};
    end
    @(negedge clk);
    w_start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) w_start = 1'b0;
      if (w_rd_en) seen.push_back(w_addr);
      if (c == 11) begin
        n_tests++;
        if (w_cnt_pat !== 4'hC || w_cnt_str !== e_str) begin
          n_fail++;
          $display("FAIL wrap_cnt: got pat=%h str=%h want c %h", w_cnt_pat, w_cnt_str, e_str);
        end
      end
    end
    n_tests++;
    if (seen.size() != 9) begin
      n_fail++;
      $display("FAIL wrap_nreads: got %0d want 9", seen.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        want_a = (i == 0) ? 8'h06 : 8'(8'hFC + i - 1);
        n_tests++;
        if (seen[i] !== want_a) begin
          n_fail++;
          $display("FAIL wrap_addr: read %0d got %h want %h", i, seen[i], want_a);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    stub_ctb = 8'h11; stub_cts = 8'h22; stub_cto = 8'h33;
    push_run(8'h11, 8'h22, 8'h33);
    push_run(8'h44, 8'h55, 8'h66);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c == 1 || c == 6 || c == 13 || c == 17) start = 1'b0;
      if (c == 5 || c == 12 || c == 14) start = 1'b1;
      if (c == 16) begin
        stub_ctb = 8'h44; stub_cts = 8'h55; stub_cto = 8'h66;
      end
      n_tests++;
      if (busy !== ((c <= 14) || (c >= 17 && c <= 30)) || done !== (c == 15 || c == 31)) begin
        n_fail++;
        $display("FAIL b2b_busy_done: cycle %0d got busy=%0b done=%0b", c, busy, done);
      end
      if (c == 16 || c == 27) begin
        n_tests++;
        if ({res_ctb, res_cts, res_cto} !== 24'h112233) begin
          n_fail++;
          $display("FAIL b2b_res_hold: cycle %0d got %h%h%h want 112233", c, res_ctb, res_cts, res_cto);
        end
      end
      if (c == 28) begin
        n_tests++;
        if ({res_ctb, res_cts, res_cto} !== 24'h445566) begin
          n_fail++;
          $display("FAIL b2b_res_new: got %h%h%h want 445566", res_ctb, res_cts, res_cto);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_left: got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_run;
    mem[40] = 8'h5A; mem[41] = 8'h5A; mem[42] = 8'h5A;
    stub_ctb = 8'h07; stub_cts = 8'h08; stub_cto = 8'h09;
    push_run(8'h07, 8'h08, 8'h09);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (all_out !== 112'd0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %h want 0", all_out);
    end
    n_tests++;
    if (exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL midrst_pending: got %0d want 2", exp_q.size());
    end
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || mem_wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_quiet: got done=%0b wr=%0b want 0 0", done, mem_wr_en);
      end
    end
    n_tests++;
    if ({mem[40], mem[41], mem[42]} !== 24'h075A5A) begin
      n_fail++;
      $display("FAIL midrst_mem: got %h%h%h want 075a5a", mem[40], mem[41], mem[42]);
    end
    rst_n = 1'b1;
    idle_cycles(2);
    push_run(8'h07, 8'h08, 8'h09);
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      n_tests++;
      if (busy !== (c <= 14) || done !== (c == 15)) begin
        n_fail++;
        $display("FAIL rerun_busy_done: cycle %0d got busy=%0b done=%0b", c, busy, done);
      end
    end
    n_tests++;
    if ({mem[40], mem[41], mem[42]} !== 24'h070809 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rerun_mem: got %h%h%h left=%0d want 070809 left=0",
               mem[40], mem[41], mem[42], exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'h00;
      wmem[i] = 8'h00;
    end
    test_reset;
    test_basic;
    idle_cycles(2);
    test_addr_seq;
    idle_cycles(2);
    test_wrap;
    idle_cycles(2);
    test_back_to_back;
    idle_cycles(2);
    test_reset_mid_run;
    idle_cycles(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_count_ctrl.md
# pattern_count_ctrl

Sequential memory front-end for the combinational pattern counter. On `start` it reads a 4-bit pattern and an 8-byte string from the byte-wide data memory and assembles them into the counter's `pat`/`str` inputs. It then samples the three counts (`ctb`, `cts`, `cto`), writes them back to memory and pulses `done`. It sits between the data memory and the counter, and is the only memory master during a run.

## Interface
Parameters:
- `PAT_ADDR`, 8'd6: address of the pattern byte; the pattern is `mem_rdata[3:0]`.
- `STR_BASE`, 8'd32: address of the first string byte; 8 consecutive bytes.
- `RES_BASE`, 8'd40: results are written to `ctb`@RES_BASE, `cts`@RES_BASE+1, `cto`@RES_BASE+2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled in IDLE only.
- `busy`  out  1  high from the first read cycle through the last write cycle.
- `done`  out  1  one-cycle pulse after the last write.
- `mem_addr`  out  8  memory address.
- `mem_rd_en`  out  1  read strobe; data returns on `mem_rdata` one cycle later (synchronous read).
- `mem_rdata`  in  8  read data.
- `mem_wr_en`  out  1  write strobe; written at the clock edge.
- `mem_wdata`  out  8  write data.
- `cnt_pat`  out  4  registered pattern to the counter.
- `cnt_str`  out  64  registered string to the counter; byte at STR_BASE+0 in [63:56], STR_BASE+7 in [7:0].
- `cnt_ctb`, `cnt_cts`, `cnt_cto`  in  8 each  counter results (combinational from `cnt_pat`/`cnt_str`).
- `res_ctb`, `res_cts`, `res_cto`  out  8 each  registered copies of the last sampled counts.

## Operation
- States: IDLE, READ, DRAIN, SAMPLE, WR0, WR1, WR2, DONE.
- IDLE:
  - All strobes low.
  - `start`=1 at an edge moves to READ and clears the read index `idx`.
- READ (9 cycles, `idx` 0..8):
  - `mem_rd_en`=1.
  - `mem_addr` = PAT_ADDR for idx 0, STR_BASE+idx-1 for idx 1..8.
  - Each cycle's address is the registered current `idx`; no address skipping.
- Capture pipeline:
  - A 1-cycle-delayed copy of `idx`/`rd_en` steers `mem_rdata` into `cnt_pat` (idx 0) or into byte slot idx-1 of `cnt_str`.
  - Byte slots not yet written keep their previous value.
- DRAIN (1 cycle): captures the final string byte. No memory access.
- SAMPLE (1 cycle): `cnt_*` are stable, and `res_*` register `cnt_ctb/cts/cto` at the end of this cycle.
- WR0/WR1/WR2:
  - `mem_wr_en`=1.
  - Addresses are RES_BASE, +1 and +2.
  - `mem_wdata` = `res_ctb`, `res_cts` and `res_cto` respectively.
- DONE: `done`=1 for one cycle, then IDLE.
- Address arithmetic is 8-bit and wraps modulo 256 (e.g. STR_BASE=8'hFC reads FC..FF, 00..03).
- `start` outside IDLE is ignored, with no queuing. `start` held high re-triggers only on the edge after DONE, when back in IDLE.
- `res_*`, `cnt_pat` and `cnt_str` hold their values between runs. A new run overwrites them.
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, idx=0; `busy`, `done`, `mem_rd_en`, `mem_wr_en`=0; `mem_addr`, `mem_wdata`, `cnt_pat`, `cnt_str`, `res_*`=0.
- With the `start` edge at the end of cycle 0, the run proceeds:
  - READ in cycles 1-9.
  - DRAIN in cycle 10.
  - SAMPLE in cycle 11.
  - WR0-WR2 in cycles 12-14.
  - `done` in cycle 15.
  - IDLE in cycle 16.
- `busy`=1 in cycles 1-14, so start-to-done latency is 15 cycles.
- `cnt_str` is complete from cycle 11. The counter has a full cycle of combinational settle before SAMPLE.
- Reset asserted mid-run: immediate return to IDLE, all outputs to their reset values. Any pending write is abandoned and no `done` is produced.

## Test plan
- Reset/idle: hold `rst_n`=0 for 3 cycles, then release and keep `start`=0 for 20 cycles. Required: every output stays 0 and no memory strobe fires.
- Basic run:
  - Stimulus: mem[6]=8'hA3 and mem[32..39]=01,23,45,67,89,AB,CD,EF; stub counter returns ctb=0A, cts=11, cto=03.
  - Required: `cnt_pat`=4'h3 and `cnt_str`=64'h0123456789ABCDEF in cycle 11.
  - Required: mem[40..42]=0A,11,03, `done` in cycle 15 only, `busy` high in cycles 1-14.
- Address sequence: log `mem_addr` under `mem_rd_en`. Required: exactly 06,20,21,...,27, then writes at 28,29,2A.
- Wrap-around: STR_BASE=8'hFC. Required: reads at FC,FD,FE,FF,00,01,02,03, with the byte at FC in `cnt_str[63:56]`.
- Ignored start and back-to-back runs: pulse `start` in cycles 5 and 12, then hold `start` high through `done`.
  - Required: the cycle-5 and cycle-12 pulses are ignored.
  - Required: a second run begins READ in cycle 17; `res_*` are unchanged until that run's SAMPLE.
- Reset mid-run: drop `rst_n` in cycle 13, during WR1. Required: outputs are 0 immediately, mem[41] and mem[42] are not written, and no `done` is produced. A subsequent `start` completes a normal 15-cycle run.
